// File: rtl/pattern_pkg.sv
// Shared definitions for the PRBS seed-word pattern detector.
package pattern_pkg;

   localparam int unsigned N_W   = 8;
   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      ST_HUNT     = 2'd0,
      ST_LOCKED   = 2'd1,
      ST_DISABLED = 2'd2
   } state_t;

   // Byte idx of the seed word, MSB byte first; the bit index is {~idx, 3'b111}.
   function automatic logic [7:0] seq_byte(input logic [31:0] seq, input logic [1:0] idx);
      return seq[{~idx, 3'b111} -: 8];
   endfunction

endpackage

// File: rtl/pattern_detector_sat_counter.sv
// Saturating up-counter; a clear takes priority over an increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_cnt <= '0;
      else if (clr)
         r_cnt <= '0;
      else if (inc && (r_cnt != {W{1'b1}}))
         r_cnt <= r_cnt + W'(1);
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/pattern_detector.sv
// Hunts for n back-to-back copies of the 32-bit seed word in a byte stream,
// then locks and counts the pseudo-random tail bytes that follow.
module pattern_detector
   import pattern_pkg::*;
#(
   parameter int unsigned N_W   = pattern_pkg::N_W,
   parameter int unsigned CNT_W = pattern_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [7:0]       data_in,
   input  logic [31:0]      seq,
   input  logic [N_W-1:0]   n,
   input  logic             clear,
   output logic             found,
   output logic             found_pulse,
   output logic [N_W-1:0]   rep_count,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] tail_cnt,
   output logic [1:0]       state
);

   state_t         r_state;
   logic [1:0]     r_idx;
   logic [N_W-1:0] r_rep;
   logic           r_found;
   logic           r_found_pulse;

   logic           w_match;
   logic           w_restart;
   logic [N_W-1:0] w_rep_inc;
   logic           w_hunt_byte;
   logic           w_mis_inc;
   logic           w_tail_inc;

   assign w_match     = (data_in == seq_byte(seq, r_idx));
   assign w_restart   = (data_in == seq_byte(seq, 2'd0));
   assign w_rep_inc   = r_rep + N_W'(1);
   assign w_hunt_byte = !clear && in_valid && (r_state == ST_HUNT) && (n != '0);
   // Only a run that had actually started counts as broken.
   assign w_mis_inc   = w_hunt_byte && !w_match && ((r_idx != 2'd0) || (r_rep != '0));
   assign w_tail_inc  = !clear && in_valid && (r_state == ST_LOCKED);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_HUNT;
         r_idx         <= 2'd0;
         r_rep         <= '0;
         r_found       <= 1'b0;
         r_found_pulse <= 1'b0;
      end else begin
         r_found_pulse <= 1'b0;
         if (clear) begin
            r_state <= ST_HUNT;
            r_idx   <= 2'd0;
            r_rep   <= '0;
            r_found <= 1'b0;
         end else begin
            case (r_state)
               ST_HUNT: begin
                  if (n == '0) begin
                     r_state <= ST_DISABLED;
                  end else if (in_valid) begin
                     if (w_match) begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                           r_rep <= w_rep_inc;
                           if (w_rep_inc == n) begin
                              r_found       <= 1'b1;
                              r_found_pulse <= 1'b1;
                              r_state       <= ST_LOCKED;
                           end
                        end
                     end else begin
                        r_rep <= '0;
                        r_idx <= w_restart ? 2'd1 : 2'd0;
                     end
                  end
               end
               ST_LOCKED: ;
               ST_DISABLED: begin
                  if (n != '0)
                     r_state <= ST_HUNT;
               end
               default: r_state <= ST_HUNT;
            endcase
         end
      end
   end

   sat_counter #(.W(CNT_W)) u_mismatch_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .inc (w_mis_inc),
      .cnt (mismatch_cnt)
   );

   sat_counter #(.W(CNT_W)) u_tail_cnt (
      .clk (clk),
      .rst (rst),
      .clr (clear),
      .inc (w_tail_inc),
      .cnt (tail_cnt)
   );

   assign found       = r_found;
   assign found_pulse = r_found_pulse;
   assign rep_count   = r_rep;
   assign state       = r_state;

endmodule

// File: doc/pattern_detector.md
# pattern_detector

Pattern detector that sits directly downstream of the PRBS byte generator. It consumes the generator's 8-bit output stream and hunts for `n` back-to-back repetitions of the 32-bit seed word `seq`, sent MSB byte first. Once it finds them, it locks and counts the pseudo-random tail bytes that follow. Status outputs feed the test controller and the debug register bank.

## Interface
Parameters:
- `N_W`, default 8: width of `n` and `rep_count`.
- `CNT_W`, default 16: width of `mismatch_cnt` and `tail_cnt`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `in_valid`, in, 1: `data_in` is valid this cycle.
- `data_in`, in, 8: byte from the PRBS generator.
- `seq`, in, 32: seed word to detect; must be static while in HUNT.
- `n`, in, `N_W`: repetitions required; must be static while in HUNT.
- `clear`, in, 1: synchronous return to HUNT; all counters zeroed.
- `found`, out, 1: sticky; set on detection.
- `found_pulse`, out, 1: single-cycle strobe on detection.
- `rep_count`, out, `N_W`: complete repetitions matched in the current run.
- `mismatch_cnt`, out, `CNT_W`: broken partial matches; saturating.
- `tail_cnt`, out, `CNT_W`: valid bytes received after lock; saturating.
- `state`, out, 2: 0 = HUNT, 1 = LOCKED, 2 = DISABLED.

## Operation
- All state and outputs are registered. Reset value of every output and internal register is 0, and `state` resets to HUNT.
- Byte index `idx` (2 bits) selects the expected byte: `exp = seq[31-8*idx -: 8]`. `idx` = 0 selects `seq[31:24]`.
- HUNT, on `in_valid`:
  - Match (`data_in == exp`):
    - `idx` < 3: `idx` increments.
    - `idx` == 3: `idx` returns to 0 and `rep_count` increments.
    - If the incremented `rep_count` equals `n`: `found` and `found_pulse` set, and state goes to LOCKED.
  - Mismatch:
    - If `idx` != 0 or `rep_count` != 0: `mismatch_cnt` increments, saturating at all-ones.
    - `rep_count` is cleared.
    - If `data_in == seq[31:24]`: `idx` goes to 1 (the byte is treated as the start of a new run). Otherwise `idx` goes to 0.
- LOCKED, on `in_valid`: `tail_cnt` increments, saturating. No further matching is done. `found` holds, `rep_count` holds, `idx` is ignored.
- DISABLED: entered from HUNT whenever `n` == 0. No counting, `found` is never set. Returns to HUNT when `n` != 0.
- `in_valid` = 0: every register holds, except that `found_pulse` clears.
- `clear`:
  - Zeroes `idx`, `rep_count`, `mismatch_cnt`, `tail_cnt`, `found`, `found_pulse`; state goes to HUNT.
  - Has priority over a same-cycle valid byte; that byte is discarded.
- `rst` mid-operation: immediate return to reset values, regardless of state.
- `seq` bytes that repeat inside the word (for example `0xAAAAAAAA`) are not specially handled. The restart rule only checks the first byte.

## Timing
- Latency of one cycle: the byte sampled on edge k updates all outputs visible after edge k.
- `found` and `found_pulse` rise on the edge that samples the last byte (`seq[7:0]`) of the n-th repetition.
- `found_pulse` stays high for exactly one cycle.
- `tail_cnt` first increments on the byte after the detecting byte.
- Back-to-back valid bytes are sustained at one byte per cycle with no stall. There is no ready or backpressure signal.
- `clear` and `in_valid` in the same cycle: `clear` wins, and the counters read 0 the next cycle.

## Structure
- Shared package `pattern_pkg`:
  - state encoding constants `ST_HUNT`, `ST_LOCKED`, `ST_DISABLED`;
  - default widths `N_W` and `CNT_W`;
  - the byte-select function `seq_byte(seq, idx)`.
- One natural sub-module: `sat_counter`, a parameterised saturating counter with `inc` and `clr` inputs. It is instantiated twice, for `mismatch_cnt` and `tail_cnt`.
- The FSM and `idx`/`rep_count` logic live in the top module.

## Test plan
- Basic detection: `seq` = `0xDEADBEEF`, `n` = 3; drive DE AD BE EF three times, then 10 random bytes → `found_pulse` on the 12th byte's edge, `rep_count` = 3, state LOCKED, `tail_cnt` = 10, `mismatch_cnt` = 0.
- Broken run with restart: `seq` = `0xDEADBEEF`, `n` = 2; drive DE AD DE AD BE EF DE AD BE EF → `mismatch_cnt` = 1, `found` after byte 10, `rep_count` = 2.
- Valid gaps: same stream as the basic case, with `in_valid` low on every other cycle → same final values as the basic case. `found_pulse` is exactly one cycle wide.
- Zero and saturation: `n` = 0 → state DISABLED and `found` stays 0 over 100 bytes. `CNT_W` = 4 with 20 tail bytes → `tail_cnt` = 15.
- Clear and reset: assert `clear` while LOCKED, in the same cycle as a valid byte → all counters 0, state HUNT. Assert `rst` mid-repetition (`idx` = 2) → all outputs 0 immediately. Re-run the basic case → detection succeeds.
